// File: rtl/desk_clock_pkg.sv
// Shared definitions for the desk clock: field widths, field limits and the
// BCD entry converter's FSM encoding.
package desk_clock_pkg;

   localparam int HRS_W = 5;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;
   localparam int BIN_W = 7;

   localparam logic [BIN_W-1:0] MAX_SECONDS = 7'd59;
   localparam logic [BIN_W-1:0] MAX_MINUTES = 7'd59;
   localparam logic [BIN_W-1:0] MAX_HOURS   = 7'd23;
   localparam logic [BIN_W-1:0] MAX_HOURS_12 = 7'd12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEC,
      ST_MIN,
      ST_HRS,
      ST_RESP
   } bcd_state_t;

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Combinational two-digit BCD to binary converter (msb*10 + lsb) with a
// flag for non-decimal digits.
module bcd_pair_to_bin
   import desk_clock_pkg::*;
(
   input  logic [3:0]       i_msb,
   input  logic [3:0]       i_lsb,
   output logic [BIN_W-1:0] o_value,
   output logic             o_digit_invalid
);

   logic [BIN_W-1:0] msb_w;
   logic [BIN_W-1:0] lsb_w;

   always_comb begin
      msb_w           = {3'b000, i_msb};
      lsb_w           = {3'b000, i_lsb};
      // Wraps for non-decimal digits; o_digit_invalid flags those cases.
      o_value         = (msb_w << 3) + (msb_w << 1) + lsb_w;
      o_digit_invalid = (i_msb > 4'd9) || (i_lsb > 4'd9);
   end

endmodule

// File: rtl/bcd_to_clock.sv
// BCD HH:MM:SS entry to binary clock-load converter, one field per cycle.
// Define BCD_TIME_12H_EN for 12-hour entry with an i_pm flag.
module bcd_to_clock
   import desk_clock_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [3:0]       i_hours_msb,
   input  logic [3:0]       i_hours_lsb,
   input  logic [3:0]       i_minutes_msb,
   input  logic [3:0]       i_minutes_lsb,
   input  logic [3:0]       i_seconds_msb,
   input  logic [3:0]       i_seconds_lsb,
`ifdef BCD_TIME_12H_EN
   input  logic             i_pm,
`endif
   output logic [HRS_W-1:0] o_hours,
   output logic [MIN_W-1:0] o_minutes,
   output logic [SEC_W-1:0] o_seconds,
   output logic             o_set,
   output logic             o_error
);

   bcd_state_t       state_q, state_d;
   logic             ready_q, ready_d;
   logic             err_q, err_d;
   logic [23:0]      digits_q, digits_d;
   logic             pm_q, pm_d;
   logic [SEC_W-1:0] sec_stage_q, sec_stage_d;
   logic [MIN_W-1:0] min_stage_q, min_stage_d;
   logic [HRS_W-1:0] hours_q, hours_d;
   logic [MIN_W-1:0] minutes_q, minutes_d;
   logic [SEC_W-1:0] seconds_q, seconds_d;
   logic             set_q, set_d;
   logic             error_q, error_d;

   logic [3:0]       conv_msb, conv_lsb;
   logic [BIN_W-1:0] conv_val;
   logic             conv_bad_digit;
   logic             field_bad;
   logic [BIN_W-1:0] hrs_bin;
   logic             pm_add;

   bcd_pair_to_bin u_conv (
      .i_msb           (conv_msb),
      .i_lsb           (conv_lsb),
      .o_value         (conv_val),
      .o_digit_invalid (conv_bad_digit)
   );

   // Steer the shared converter to the field owned by the current state.
   always_comb begin
      conv_msb = digits_q[7:4];
      conv_lsb = digits_q[3:0];
      case (state_q)
         ST_MIN: begin
            conv_msb = digits_q[15:12];
            conv_lsb = digits_q[11:8];
         end
         ST_HRS: begin
            conv_msb = digits_q[23:20];
            conv_lsb = digits_q[19:16];
         end
         default: ;
      endcase
   end

   always_comb begin
      pm_add = 1'b0;
`ifdef BCD_TIME_12H_EN
      pm_add = pm_q;
      if (conv_val == MAX_HOURS_12)
         hrs_bin = pm_q ? MAX_HOURS_12 : '0;
      else
         hrs_bin = conv_val + (pm_add ? 7'd12 : 7'd0);
`else
      hrs_bin = conv_val + (pm_add ? 7'd12 : 7'd0);
`endif
      case (state_q)
         ST_SEC:  field_bad = conv_bad_digit || (conv_val > MAX_SECONDS);
         ST_MIN:  field_bad = conv_bad_digit || (conv_val > MAX_MINUTES);
`ifdef BCD_TIME_12H_EN
         ST_HRS:  field_bad = conv_bad_digit || (conv_val == '0) ||
                              (conv_val > MAX_HOURS_12);
`else
         ST_HRS:  field_bad = conv_bad_digit || (conv_val > MAX_HOURS);
`endif
         default: field_bad = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      digits_d    = digits_q;
      pm_d        = pm_q;
      sec_stage_d = sec_stage_q;
      min_stage_d = min_stage_q;
      hours_d     = hours_q;
      minutes_d   = minutes_q;
      seconds_d   = seconds_q;
      set_d       = 1'b0;
      error_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_valid && ready_q) begin
               digits_d = {i_hours_msb, i_hours_lsb, i_minutes_msb,
                           i_minutes_lsb, i_seconds_msb, i_seconds_lsb};
`ifdef BCD_TIME_12H_EN
               pm_d     = i_pm;
`endif
               err_d    = 1'b0;
               state_d  = ST_SEC;
            end
         end
         ST_SEC: begin
            sec_stage_d = conv_val[SEC_W-1:0];
            err_d       = err_q | field_bad;
            state_d     = ST_MIN;
         end
         ST_MIN: begin
            min_stage_d = conv_val[MIN_W-1:0];
            err_d       = err_q | field_bad;
            state_d     = ST_HRS;
         end
         ST_HRS: begin
            // Outputs and strobes are registered here so they are visible
            // during the RESP cycle.
            err_d   = err_q | field_bad;
            if (err_q | field_bad) begin
               error_d = 1'b1;
            end else begin
               set_d     = 1'b1;
               hours_d   = hrs_bin[HRS_W-1:0];
               minutes_d = min_stage_q;
               seconds_d = sec_stage_q;
            end
            state_d = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
         digits_q    <= '0;
         pm_q        <= 1'b0;
         sec_stage_q <= '0;
         min_stage_q <= '0;
         hours_q     <= '0;
         minutes_q   <= '0;
         seconds_q   <= '0;
         set_q       <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
         digits_q    <= digits_d;
         pm_q        <= pm_d;
         sec_stage_q <= sec_stage_d;
         min_stage_q <= min_stage_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         seconds_q   <= seconds_d;
         set_q       <= set_d;
         error_q     <= error_d;
      end
   end

   assign o_ready   = ready_q;
   assign o_hours   = hours_q;
   assign o_minutes = minutes_q;
   assign o_seconds = seconds_q;
   assign o_set     = set_q;
   assign o_error   = error_q;

endmodule

// File: tb/tb_bcd_to_clock.sv
// Directed, table-driven bench for bcd_to_clock (24h default, 12h when
// BCD_TIME_12H_EN is defined).
module tb_bcd_to_clock;

   typedef struct {
      string       name;
      logic [23:0] digits;  // HH MM SS as six BCD nibbles
      logic        pm;
      logic        exp_set;
      int          eh;
      int          em;
      int          es;
   } vec_t;

   logic       i_clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic       i_valid = 1'b0;
   logic [23:0] dig = '0;
   logic       o_ready;
   logic [4:0] o_hours;
   logic [5:0] o_minutes;
   logic [5:0] o_seconds;
   logic       o_set;
   logic       o_error;
`ifdef BCD_TIME_12H_EN
   logic       i_pm = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   bcd_to_clock dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_hours_msb   (dig[23:20]),
      .i_hours_lsb   (dig[19:16]),
      .i_minutes_msb (dig[15:12]),
      .i_minutes_lsb (dig[11:8]),
      .i_seconds_msb (dig[7:4]),
      .i_seconds_lsb (dig[3:0]),
`ifdef BCD_TIME_12H_EN
      .i_pm          (i_pm),
`endif
      .o_hours       (o_hours),
      .o_minutes     (o_minutes),
      .o_seconds     (o_seconds),
      .o_set         (o_set),
      .o_error       (o_error)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input int eh, input int em, input int es);
      chk({name, " hours"},   int'(o_hours),   eh);
      chk({name, " minutes"}, int'(o_minutes), em);
      chk({name, " seconds"}, int'(o_seconds), es);
   endtask

   task automatic add(input string n, input logic [23:0] d, input logic pm,
                      input logic s, input int eh, input int em, input int es);
      vec_t v;
      v.name = n; v.digits = d; v.pm = pm; v.exp_set = s;
      v.eh = eh; v.em = em; v.es = es;
      vecs.push_back(v);
   endtask

   // Called at a negedge; returns at a negedge with o_ready high or a failure logged.
   task automatic wait_ready(input string name);
      for (int i = 0; i < 30; i++) begin
         if (o_ready) return;
         @(negedge i_clk);
      end
      chk({name, " ready timeout"}, int'(o_ready), 1);
   endtask

   task automatic drive(input logic [23:0] d, input logic pm);
      dig     = d;
`ifdef BCD_TIME_12H_EN
      i_pm    = pm;
`else
      if (pm) dig = d;
`endif
      i_valid = 1'b1;
   endtask

   task automatic apply(input vec_t v);
      wait_ready(v.name);
      drive(v.digits, v.pm);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      dig     = 24'hFFFFFF;  // post-accept changes must not matter
      for (int c = 1; c <= 5; c++) begin
         @(negedge i_clk);
         chk($sformatf("%s c%0d ready", v.name, c), int'(o_ready), (c == 5) ? 1 : 0);
         chk($sformatf("%s c%0d set", v.name, c), int'(o_set),
             (c == 4 && v.exp_set) ? 1 : 0);
         chk($sformatf("%s c%0d error", v.name, c), int'(o_error),
             (c == 4 && !v.exp_set) ? 1 : 0);
         if (c == 4) chk_out(v.name, v.eh, v.em, v.es);
      end
   endtask

   initial begin
`ifdef BCD_TIME_12H_EN
      add("pm12_34_56",   24'h123456, 1'b1, 1'b1, 12, 34, 56);
      add("am12_00_00",   24'h120000, 1'b0, 1'b1,  0,  0,  0);
      add("pm12_15_00",   24'h121500, 1'b1, 1'b1, 12, 15,  0);
      add("pm07_00_00",   24'h070000, 1'b1, 1'b1, 19,  0,  0);
      add("am07_00_00",   24'h070000, 1'b0, 1'b1,  7,  0,  0);
      add("err_h00",      24'h000000, 1'b0, 1'b0,  7,  0,  0);
      add("err_h13",      24'h131000, 1'b1, 1'b0,  7,  0,  0);
      add("err_m60",      24'h126000, 1'b0, 1'b0,  7,  0,  0);
      add("err_s_lsbA",   24'h01000A, 1'b0, 1'b0,  7,  0,  0);
      add("am01_59_59",   24'h015959, 1'b0, 1'b1,  1, 59, 59);
`else
      add("t12_34_56",    24'h123456, 1'b0, 1'b1, 12, 34, 56);
      add("t23_59_59",    24'h235959, 1'b0, 1'b1, 23, 59, 59);
      add("err_h24",      24'h240000, 1'b0, 1'b0, 23, 59, 59);
      add("err_m60",      24'h126000, 1'b0, 1'b0, 23, 59, 59);
      add("err_s_lsbA",   24'h00000A, 1'b0, 1'b0, 23, 59, 59);
      add("t00_00_00",    24'h000000, 1'b0, 1'b1,  0,  0,  0);
      add("t09_05_07",    24'h090507, 1'b0, 1'b1,  9,  5,  7);
      add("err_h_lsbA",   24'h1A0000, 1'b0, 1'b0,  9,  5,  7);
      add("err_s60",      24'h005960, 1'b0, 1'b0,  9,  5,  7);
`endif

      // Reset state
      repeat (3) @(negedge i_clk);
      chk("reset ready", int'(o_ready), 0);
      chk("reset set", int'(o_set), 0);
      chk("reset error", int'(o_error), 0);
      chk_out("reset", 0, 0, 0);
      i_reset_n = 1'b1;
      @(negedge i_clk);
      chk("post-reset ready", int'(o_ready), 1);

      foreach (vecs[i]) apply(vecs[i]);

      // Busy: i_valid held with different digits during k+1..k+3 is ignored
      wait_ready("busy");
      drive(24'h102030, 1'b0);
      @(posedge i_clk);
      #1;
      dig = 24'h010203;
      for (int c = 1; c <= 7; c++) begin
         @(negedge i_clk);
         if (c <= 4)
            chk($sformatf("busy c%0d ready", c), int'(o_ready), 0);
         if (c == 4) begin
            chk("busy c4 set", int'(o_set), 1);
            chk_out("busy c4", 10, 20, 30);
            i_valid = 1'b0;
         end else begin
            chk($sformatf("busy c%0d set", c), int'(o_set), 0);
         end
         chk($sformatf("busy c%0d error", c), int'(o_error), 0);
      end
      chk("busy ready after", int'(o_ready), 1);
      chk_out("busy after", 10, 20, 30);

      // Reset during MIN aborts the conversion
      wait_ready("rst");
      drive(24'h050607, 1'b0);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b0;
      @(negedge i_clk);
      chk("midrst ready", int'(o_ready), 0);
      chk("midrst set", int'(o_set), 0);
      chk("midrst error", int'(o_error), 0);
      chk_out("midrst", 0, 0, 0);
      i_reset_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge i_clk);
         if (c == 1) chk("midrst release ready", int'(o_ready), 1);
         chk($sformatf("midrst c%0d set", c), int'(o_set), 0);
         chk($sformatf("midrst c%0d error", c), int'(o_error), 0);
      end
      begin
         vec_t v;
         v.name = "after_rst"; v.digits = 24'h070809; v.pm = 1'b0;
         v.exp_set = 1'b1; v.eh = 7; v.em = 8; v.es = 9;
         apply(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
